ex_stage_mdu: RTL and testbench

- Parametrised execute stage for the pipelined MIPS core: forwarding muxes, ALU, destination select and the EX/MEM pipeline register.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, a stall output to the hazard unit, and an EX-side flush.
- Sits between the ID/EX register and the MEM stage.

---
 rtl/ex_stage_mdu_pkg.sv | 33 +++
 rtl/ex_stage_mdu_if.sv | 34 +++
 rtl/mdu_iter.sv | 147 ++++++++++++++
 rtl/ex_stage_mdu.sv | 142 ++++++++++++++
 tb/tb_ex_stage_mdu.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_mdu_pkg.sv
// Shared constants for the EX stage: ALU opcodes, forward selects, MDU types.
// Ports: none (package ex_pkg).
package ex_pkg;

    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_ADD   = 5'd2;
    localparam logic [4:0] OP_SLL   = 5'd3;
    localparam logic [4:0] OP_SRL   = 5'd4;
    localparam logic [4:0] OP_SRA   = 5'd5;
    localparam logic [4:0] OP_SUB   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_XOR   = 5'd9;
    localparam logic [4:0] OP_NOR   = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;

    localparam logic [1:0] FWD_RD = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// slave: used by ex_stage_mdu; master: used by the driving side.
interface ex_stage_mdu_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5,
    parameter int unsigned OPW   = 5
);
    logic             RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [OPW-1:0]   ALUControlE;
    logic [RADDR-1:0] RsE, RtE, RdE;
    logic [4:0]       shamtE;
    logic [XLEN-1:0]  RD1E, RD2E, SignImmE, ResultW;
    logic             StallE, MduBusy;
    logic [RADDR-1:0] WriteRegE, WriteRegM;
    logic             RegWriteM, MemtoRegM, MemWriteM;
    logic [XLEN-1:0]  ALUOutM, WriteDataM;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE,
               ForwardAE, ForwardBE, ALUControlE, RsE, RtE, RdE, shamtE,
               RD1E, RD2E, SignImmE, ResultW,
        input  StallE, MduBusy, WriteRegE, WriteRegM, RegWriteM, MemtoRegM,
               MemWriteM, ALUOutM, WriteDataM
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE,
               ForwardAE, ForwardBE, ALUControlE, RsE, RtE, RdE, shamtE,
               RD1E, RD2E, SignImmE, ResultW,
        output StallE, MduBusy, WriteRegE, WriteRegM, RegWriteM, MemtoRegM,
               MemWriteM, ALUOutM, WriteDataM
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide with HI/LO: one bit per cycle for XLEN cycles.
// Ports: clk, rst_n, start_i, op_i (00 MULT 01 MULTU 10 DIV 11 DIVU),
//        a_i, b_i, busy_o, hi_o, lo_o.
// Macro MDU_DIV_EN: when undefined the divider is absent and div starts are ignored.
module mdu_iter
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d, quo_q, quo_d, opd_q, opd_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              neg_q, neg_d;
    logic              start_ok, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod, prod_fix;
`ifdef MDU_DIV_EN
    logic              div_q, div_d, rneg_q, rneg_d;
    logic [XLEN:0]     trial;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
`ifdef MDU_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Next state: operand latch in IDLE, one iteration per RUN cycle, sign fix-up in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
`ifdef MDU_DIV_EN
        div_d    = div_q;
        rneg_d   = rneg_q;
        start_ok = start_i;
        trial    = {acc_q, quo_q[XLEN-1]} - {1'b0, opd_q};
`else
        start_ok = start_i & ~op_i[1];
`endif
        sa       = ~op_i[0] & a_i[XLEN-1];
        sb       = ~op_i[0] & b_i[XLEN-1];
        a_mag    = sa ? -a_i : a_i;
        b_mag    = sb ? -b_i : b_i;
        mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opd_q} : '0);
        prod     = {acc_q, quo_q};
        prod_fix = neg_q ? -prod : prod;

        case (state_q)
            MDU_IDLE: begin
                if (start_ok) begin
                    state_d = MDU_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    quo_d   = a_mag;
                    opd_d   = b_mag;
                    // A zero divisor keeps the all-ones quotient unsigned.
                    neg_d   = (sa ^ sb) & (|b_i);
`ifdef MDU_DIV_EN
                    div_d   = op_i[1];
                    rneg_d  = sa;
`endif
                end
            end
            MDU_RUN: begin
                // Shift-add: {acc, quo} shifts right with the partial sum entering at the top.
                acc_d = mul_sum[XLEN:1];
                quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
                // Restoring divide: acc is the remainder, quo shifts dividend out and quotient in.
                if (div_q) begin
                    if (!trial[XLEN]) begin
                        acc_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
                if (div_q) begin
                    lo_d = neg_q ? -quo_q : quo_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end
`endif
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    assign busy_o = (state_q != MDU_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: forwarding, ALU, destination select, EX/MEM register, MDU.
// Ports: clk, rst_n (async active-low), ex_io (ex_stage_mdu_if.slave) carrying
//        ID/EX controls/operands in and StallE, MduBusy, WriteRegE, M-stage out.
// Macro MDU_DIV_EN: enables DIV/DIVU; otherwise codes 18/19 act as NOP.
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5,
    parameter int unsigned OPW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_stage_mdu_if.slave ex_io
);
    logic [XLEN-1:0]  src_a, src_b, wdata_e, alu_res, hi, lo;
    logic [RADDR-1:0] wreg_e;
    logic             is_mdu, hilo_op, stall, start, busy, bubble;

    logic             reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
    logic             mem_write_q, mem_write_d;
    logic [RADDR-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]  alu_out_q, alu_out_d, wdata_q, wdata_d;

    // Forwarding muxes and operand/destination selection.
    always_comb begin
        case (ex_io.ForwardAE)
            FWD_W:   src_a = ex_io.ResultW;
            FWD_M:   src_a = alu_out_q;
            default: src_a = ex_io.RD1E;
        endcase
        case (ex_io.ForwardBE)
            FWD_W:   wdata_e = ex_io.ResultW;
            FWD_M:   wdata_e = alu_out_q;
            default: wdata_e = ex_io.RD2E;
        endcase
        src_b  = ex_io.ALUSrcE ? ex_io.SignImmE : wdata_e;
        wreg_e = ex_io.RegDstE ? ex_io.RdE : ex_io.RtE;
    end

    // ALU; hilo_op marks the codes that must wait for a busy MDU.
    always_comb begin
        alu_res = '0;
        is_mdu  = 1'b0;
        hilo_op = 1'b0;
        case (ex_io.ALUControlE)
            OPW'(OP_AND):  alu_res = src_a & src_b;
            OPW'(OP_OR):   alu_res = src_a | src_b;
            OPW'(OP_ADD):  alu_res = src_a + src_b;
            OPW'(OP_SLL):  alu_res = src_b << ex_io.shamtE;
            OPW'(OP_SRL):  alu_res = src_b >> ex_io.shamtE;
            OPW'(OP_SRA):  alu_res = $signed(src_b) >>> ex_io.shamtE;
            OPW'(OP_SUB):  alu_res = src_a - src_b;
            OPW'(OP_SLT):  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OPW'(OP_SLTU): alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OPW'(OP_XOR):  alu_res = src_a ^ src_b;
            OPW'(OP_NOR):  alu_res = ~(src_a | src_b);
            OPW'(OP_MULT), OPW'(OP_MULTU): begin
                is_mdu  = 1'b1;
                hilo_op = 1'b1;
            end
            OPW'(OP_DIV), OPW'(OP_DIVU): begin
                is_mdu  = 1'b1;
`ifdef MDU_DIV_EN
                hilo_op = 1'b1;
`endif
            end
            OPW'(OP_MFHI): begin
                alu_res = hi;
                hilo_op = 1'b1;
            end
            OPW'(OP_MFLO): begin
                alu_res = lo;
                hilo_op = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    assign stall = busy & hilo_op;
    assign start = is_mdu & hilo_op & ~stall & ~ex_io.FlushE;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (ex_io.ALUControlE[1:0]),
        .a_i     (src_a),
        .b_i     (wdata_e),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // EX/MEM next value: a bubble on stall or flush, otherwise the EX results.
    always_comb begin
        bubble       = stall | ex_io.FlushE;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        wreg_d       = '0;
        alu_out_d    = '0;
        wdata_d      = '0;
        if (!bubble) begin
            reg_write_d  = ex_io.RegWriteE & ~is_mdu;
            mem_to_reg_d = ex_io.MemtoRegE;
            mem_write_d  = ex_io.MemWriteE;
            wreg_d       = wreg_e;
            alu_out_d    = alu_res;
            wdata_d      = wdata_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            wreg_q       <= '0;
            alu_out_q    <= '0;
            wdata_q      <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            wreg_q       <= wreg_d;
            alu_out_q    <= alu_out_d;
            wdata_q      <= wdata_d;
        end
    end

    assign ex_io.StallE     = stall;
    assign ex_io.MduBusy    = busy;
    assign ex_io.WriteRegE  = wreg_e;
    assign ex_io.RegWriteM  = reg_write_q;
    assign ex_io.MemtoRegM  = mem_to_reg_q;
    assign ex_io.MemWriteM  = mem_write_q;
    assign ex_io.WriteRegM  = wreg_q;
    assign ex_io.ALUOutM    = alu_out_q;
    assign ex_io.WriteDataM = wdata_q;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed self-checking bench for ex_stage_mdu (XLEN 32).
module tb_ex_stage_mdu;
    import ex_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] lo_v, hi_v;
    int   n;

    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(32), .RADDR(5), .OPW(5)) bus ();

    ex_stage_mdu #(.XLEN(32), .RADDR(5), .OPW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex_io (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ALUControlE = op;
        bus.RD1E        = a;
        bus.RD2E        = b;
        bus.ForwardAE   = FWD_RD;
        bus.ForwardBE   = FWD_RD;
        bus.ALUSrcE     = 1'b0;
        bus.RegWriteE   = 1'b1;
        bus.MemtoRegE   = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.RegDstE     = 1'b1;
        bus.FlushE      = 1'b0;
        bus.RsE         = 5'd1;
        bus.RtE         = 5'd4;
        bus.RdE         = 5'd9;
        bus.shamtE      = 5'd0;
        bus.SignImmE    = 32'd0;
        bus.ResultW     = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        drive(op, a, b);
        bus.shamtE = sh;
        step();
        chk(tag, bus.ALUOutM, exp);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        drive(OP_ADD, 32'd0, 32'd0);
        bus.RegWriteE = 1'b0;
        k = 0;
        while (bus.MduBusy === 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk(tag, bus.MduBusy, 1'b0);
    endtask

    task automatic read_hilo(output logic [31:0] lo_o, output logic [31:0] hi_o);
        drive(OP_MFLO, 32'd0, 32'd0);
        step();
        lo_o = bus.ALUOutM;
        drive(OP_MFHI, 32'd0, 32'd0);
        step();
        hi_o = bus.ALUOutM;
    endtask

    task automatic mdu_case(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        logic [31:0] l, h;
        drive(op, a, b);
        step();
        wait_idle({tag, "_idle"});
        read_hilo(l, h);
        chk({tag, "_lo"}, l, exp_lo);
        chk({tag, "_hi"}, h, exp_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(OP_AND, 32'd0, 32'd0);
        bus.RegWriteE = 1'b0;
        #12;
        chk("rst_aluout", bus.ALUOutM, 0);
        chk("rst_regwr", bus.RegWriteM, 0);
        chk("rst_busy", bus.MduBusy, 0);
        rst_n = 1'b1;
        step();

        // Forwarding
        alu_vec("fwd_seed", OP_ADD, 32'd7, 32'd0, 5'd0, 32'd7);
        chk("fwd_seed_wreg", bus.WriteRegM, 9);
        chk("fwd_seed_rw", bus.RegWriteM, 1);
        drive(OP_ADD, 32'd5, 32'd3);
        bus.ForwardAE = FWD_M;
        step();
        chk("fwd_m", bus.ALUOutM, 10);
        drive(OP_ADD, 32'd5, 32'd3);
        bus.ForwardAE = FWD_W;
        bus.ResultW   = 32'd1;
        step();
        chk("fwd_w", bus.ALUOutM, 4);
        drive(OP_SUB, 32'd6, 32'd100);
        bus.ForwardAE = 2'd3;
        bus.ForwardBE = FWD_M;
        step();
        chk("fwd_b_m", bus.ALUOutM, 2);
        chk("fwd_b_wdata", bus.WriteDataM, 4);

        // ALU table
        alu_vec("and",  OP_AND,  32'hF0F0, 32'hFF00, 5'd0, 32'hF000);
        alu_vec("or",   OP_OR,   32'hF0F0, 32'h0F00, 5'd0, 32'hFFF0);
        alu_vec("addw", OP_ADD,  32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1);
        alu_vec("sub",  OP_SUB,  32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        alu_vec("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        alu_vec("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        alu_vec("xor",  OP_XOR,  32'hFF, 32'h0F, 5'd0, 32'hF0);
        alu_vec("nor",  OP_NOR,  32'd0, 32'hFFFF_0000, 5'd0, 32'h0000_FFFF);
        alu_vec("sll",  OP_SLL,  32'd0, 32'd1, 5'd4, 32'h10);
        alu_vec("srl",  OP_SRL,  32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
        alu_vec("sra",  OP_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        alu_vec("undef", 5'd15,  32'd3, 32'd5, 5'd0, 32'd0);
        drive(OP_ADD, 32'd1, 32'd2);
        bus.RegDstE = 1'b0;
        #1;
        chk("wreg_e_rt", bus.WriteRegE, 4);

        // MULT then MFLO: stall for XLEN+1 cycles, bubbles into M
        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        step();
        chk("mult_aluout", bus.ALUOutM, 0);
        chk("mult_rw", bus.RegWriteM, 0);
        chk("mult_busy", bus.MduBusy, 1);
        drive(OP_MFLO, 32'd0, 32'd0);
        #1;
        n = 0;
        while (bus.StallE === 1'b1 && n < 100) begin
            n++;
            step();
            chk("mult_bubble", {bus.RegWriteM, bus.ALUOutM}, 0);
        end
        chk("mult_stall_len", n, XLEN + 1);
        step();
        chk("mflo", bus.ALUOutM, 32'hFFFF_FFFA);
        chk("mflo_rw", bus.RegWriteM, 1);
        drive(OP_MFHI, 32'd0, 32'd0);
        step();
        chk("mfhi", bus.ALUOutM, 32'hFFFF_FFFF);

`ifdef MDU_DIV_EN
        mdu_case("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        mdu_case("divu_0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
        mdu_case("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
`else
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        step();
        chk("div_nop_busy", bus.MduBusy, 0);
        chk("div_nop_rw", bus.RegWriteM, 0);
        read_hilo(lo_v, hi_v);
        chk("div_nop_lo", lo_v, 32'hFFFF_FFFA);
        chk("div_nop_hi", hi_v, 32'hFFFF_FFFF);
`endif

        // Overlap: non-MDU work proceeds while the MDU runs
        drive(OP_MULTU, 32'h1_0000, 32'h1_0000);
        step();
        chk("ovl_busy", bus.MduBusy, 1);
        drive(OP_ADD, 32'd2, 32'd3);
        #1;
        chk("ovl_add_nostall", bus.StallE, 0);
        step();
        chk("ovl_add", bus.ALUOutM, 5);
        chk("ovl_add_rw", bus.RegWriteM, 1);
        drive(OP_ADD, 32'h100, 32'hAB);
        bus.ALUSrcE   = 1'b1;
        bus.SignImmE  = 32'd4;
        bus.MemWriteE = 1'b1;
        bus.RegWriteE = 1'b0;
        step();
        chk("ovl_sw_addr", bus.ALUOutM, 32'h104);
        chk("ovl_sw_data", bus.WriteDataM, 32'hAB);
        chk("ovl_sw_mw", bus.MemWriteM, 1);
        drive(OP_DIV, 32'd8, 32'd2);
        #1;
`ifdef MDU_DIV_EN
        chk("ovl_div_stall", bus.StallE, 1);
`else
        chk("ovl_div_stall", bus.StallE, 0);
`endif
        drive(OP_ADD, 32'd1, 32'd1);
        bus.FlushE = 1'b1;
        step();
        chk("ovl_flush_bubble", {bus.RegWriteM, bus.ALUOutM}, 0);
        chk("ovl_flush_busy", bus.MduBusy, 1);
        wait_idle("ovl_idle");
        read_hilo(lo_v, hi_v);
        chk("ovl_lo", lo_v, 0);
        chk("ovl_hi", hi_v, 1);

        // Flush cancels an MDU op that has not started
        drive(OP_MULT, 32'd5, 32'd5);
        bus.FlushE = 1'b1;
        step();
        chk("flush_busy", bus.MduBusy, 0);
        chk("flush_bubble", {bus.RegWriteM, bus.ALUOutM}, 0);
        read_hilo(lo_v, hi_v);
        chk("flush_lo", lo_v, 0);
        chk("flush_hi", hi_v, 1);

        // Mid-cycle async reset with the MDU running and random inputs
        drive(OP_MULT, 32'd3, 32'd4);
        step();
        for (int i = 0; i < 5; i++) begin
            bus.ALUControlE = 5'($urandom_range(0, 21));
            bus.RD1E        = $urandom;
            bus.RD2E        = $urandom;
            bus.ForwardAE   = 2'($urandom_range(0, 3));
            bus.ForwardBE   = 2'($urandom_range(0, 3));
            bus.RegWriteE   = 1'($urandom_range(0, 1));
            bus.MemWriteE   = 1'($urandom_range(0, 1));
            bus.MemtoRegE   = 1'b1;
            step();
        end
        bus.ALUControlE = OP_ADD;
        bus.RD1E        = 32'd1;
        bus.ForwardAE   = FWD_RD;
        bus.FlushE      = 1'b0;
        bus.RegWriteE   = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_aluout", bus.ALUOutM, 0);
        chk("arst_ctrl", {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 0);
        chk("arst_wreg", bus.WriteRegM, 0);
        chk("arst_wdata", bus.WriteDataM, 0);
        chk("arst_busy", bus.MduBusy, 0);
        chk("arst_hi", dut.u_mdu.hi_q, 0);
        chk("arst_lo", dut.u_mdu.lo_q, 0);
        drive(OP_ADD, 32'd0, 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", bus.MduBusy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
